// File: rtl/logic_unit_arbiter.sv
// -----------------------------------------------------------------------------
// logic_unit_arbiter
//
// Purpose:
//   Shares one registered bitwise logic unit (AND/OR/NAND/NOR/XOR/XNOR) among
//   NUM_REQ requesters. Each requester has its own valid/ready request port.
//   Results come back on a single response channel, tagged with the index of
//   the requester that owns them. Each operation takes three states:
//   IDLE (accept) -> EXEC (compute) -> RESP (hold until consumed).
//
// Configuration macro:
//   LOGIC_ARB_RR_EN  defined   : round-robin arbitration. The search starts at
//                                last_grant+1 and wraps. Requester 0 has
//                                highest priority after reset.
//                    undefined : fixed priority, where the lowest index wins.
//                                No pointer register is built.
//   The port list and timing are the same in both builds.
//
// Ports:
//   clk        in   1              clock, rising edge
//   rst        in   1              synchronous active-high reset
//   req_valid  in   NUM_REQ        per-requester request valid
//   req_op     in   3*NUM_REQ      op code, requester i at [3i+2:3i]
//   req_a      in   WIDTH*NUM_REQ  operand A, requester i at [WIDTH*i +: WIDTH]
//   req_b      in   WIDTH*NUM_REQ  operand B, packed like req_a
//   req_ready  out  NUM_REQ        one-hot accept pulse to the granted requester
//   rsp_valid  out  1              response valid
//   rsp_ready  in   1              response consumer ready
//   rsp_id     out  IDW            owner of the response
//   rsp_data   out  WIDTH          result
//   rsp_err    out  1              illegal op code (6/7)
//   busy       out  1              high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module logic_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int IDW     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [3*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_err,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic               grant_found;
  logic [IDW-1:0]     grant_idx;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [2:0]         sel_op;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;

  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;

`ifdef LOGIC_ARB_RR_EN
  logic [IDW-1:0]     last_grant;

  // Round-robin search is done in two passes so that no index arithmetic
  // with a modulo is needed. The first pass covers requesters above
  // last_grant. The second pass wraps around to 0..last_grant.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[i] && (i > int'(last_grant))) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[i] && (i <= int'(last_grant))) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(i);
      end
    end
  end
`else
  // Fixed priority: the lowest-indexed valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[i]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(i);
      end
    end
  end
`endif

  // Build the one-hot grant and mux out the winner's op/operands.
  always_comb begin
    grant_onehot = '0;
    sel_op       = '0;
    sel_a        = '0;
    sel_b        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_found && (grant_idx == IDW'(i))) begin
        grant_onehot[i] = 1'b1;
        sel_op          = req_op[3*i +: 3];
        sel_a           = req_a[WIDTH*i +: WIDTH];
        sel_b           = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs. req_ready is only ever asserted in IDLE,
  // so an accept and a response completion can never occur in the same cycle.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready = grant_onehot;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: latch the winning request on accept, then compute the result in
  // EXEC. The result registers stay untouched in RESP, which keeps them stable
  // under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if ((state_q == IDLE) && grant_found) begin
        op_q   <= sel_op;
        a_q    <= sel_a;
        b_q    <= sel_b;
        rsp_id <= grant_idx;
      end
      if (state_q == EXEC) begin
        rsp_err <= 1'b0;
        case (op_q)
          3'd0:    rsp_data <= a_q & b_q;
          3'd1:    rsp_data <= a_q | b_q;
          3'd2:    rsp_data <= ~(a_q & b_q);
          3'd3:    rsp_data <= ~(a_q | b_q);
          3'd4:    rsp_data <= a_q ^ b_q;
          3'd5:    rsp_data <= ~(a_q ^ b_q);
          default: begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef LOGIC_ARB_RR_EN
  // The pointer moves on accept only. Its reset value of NUM_REQ-1 makes
  // requester 0 the first candidate.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= IDW'(NUM_REQ - 1);
    end else if ((state_q == IDLE) && grant_found) begin
      last_grant <= grant_idx;
    end
  end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_arbiter
//
// Self-checking bench for logic_unit_arbiter (NUM_REQ=4, WIDTH=8).
// A reference model tracks the FSM, arbitration and pointer. When it predicts
// an accept, it pushes the expected response onto a scoreboard queue. The
// response monitor compares every cycle spent in RESP against the head of
// that queue and pops the entry on the handshake.
// Build with +define+LOGIC_ARB_RR_EN to check the round-robin variant.
// -----------------------------------------------------------------------------
module tb_logic_unit_arbiter;

  localparam int N = 4;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0][2:0] op_p;
  logic [N-1:0][7:0] a_p;
  logic [N-1:0][7:0] b_p;
  logic [N-1:0]     req_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic [7:0]       rsp_data;
  logic             rsp_err;
  logic             busy;

  logic [3*N-1:0]   req_op;
  logic [8*N-1:0]   req_a;
  logic [8*N-1:0]   req_b;

  assign req_op = op_p;
  assign req_a  = a_p;
  assign req_b  = b_p;

  logic_unit_arbiter #(.NUM_REQ(N), .WIDTH(8), .IDW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   vectors = 0;
  int   errors  = 0;
  int   mstate  = 0;
  int   mptr    = N - 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t modelOp(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.id  = id;
    e.err = 1'b0;
    case (op)
      3'd0: e.data = a & b;
      3'd1: e.data = a | b;
      3'd2: e.data = ~(a & b);
      3'd3: e.data = ~(a | b);
      3'd4: e.data = a ^ b;
      3'd5: e.data = ~(a ^ b);
      default: begin
        e.data = 8'h00;
        e.err  = 1'b1;
      end
    endcase
    return e;
  endfunction

  function automatic int modelArb(input logic [N-1:0] v, input int ptr);
`ifdef LOGIC_ARB_RR_EN
    for (int k = 1; k <= N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
`else
    for (int i = 0; i < N; i++) begin
      if (v[i]) return i;
    end
`endif
    return -1;
  endfunction

  // Reference model and response monitor. Outputs are compared at the
  // negative edge. The model then advances to the state the DUT reaches at
  // the next rising edge.
  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    int g;
    g = -1;
    exp_ready = '0;
    if (mstate == 0 && req_valid != '0) begin
      g = modelArb(req_valid, mptr);
      exp_ready[g] = 1'b1;
    end
    if (exp_ready != '0 || req_ready != '0)
      checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
    for (int i = 0; i < N; i++)
      if (req_ready[i]) grant_log.push_back(i);
    checkOutput("busy", 32'(busy), 32'(mstate != 0));
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(mstate == 2));
    if (mstate == 2) begin
      if (sb.size() == 0) begin
        checkOutput("rsp_unexpected", 32'(rsp_id), 32'hFFFF_FFFF);
      end else begin
        checkOutput("sb_rsp_id", 32'(rsp_id), 32'(sb[0].id));
        checkOutput("sb_rsp_data", 32'(rsp_data), 32'(sb[0].data));
        checkOutput("sb_rsp_err", 32'(rsp_err), 32'(sb[0].err));
      end
    end
    if (rst) begin
      mstate = 0;
      mptr   = N - 1;
      sb.delete();
    end else begin
      case (mstate)
        0: if (g >= 0) begin
             sb.push_back(modelOp(g, op_p[g], a_p[g], b_p[g]));
             mptr   = g;
             mstate = 1;
           end
        1: mstate = 2;
        2: if (rsp_ready) begin
             if (sb.size() != 0) void'(sb.pop_front());
             mstate = 0;
           end
        default: mstate = 0;
      endcase
    end
  end

  // Drive one request and hold it until its ready is seen, then drop valid
  // just after the accepting edge. Called shortly after a rising edge.
  task automatic applyStimulus(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bit seen;
    seen = 1'b0;
    op_p[id] = op;
    a_p[id]  = a;
    b_p[id]  = b;
    req_valid[id] = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput("grant_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic waitIdle();
    bit idle;
    idle = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!busy) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) checkOutput("idle_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Full operation with an explicit latency check: rsp_valid is low in the
  // cycle after the accept and high two cycles after it.
  task automatic doOp(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] ed, input logic ee);
    applyStimulus(id, op, a, b);
    @(negedge clk);
    checkOutput("lat_t1_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    checkOutput("lat_t2_valid", 32'(rsp_valid), 32'd1);
    checkOutput("op_rsp_id", 32'(rsp_id), 32'(id));
    checkOutput("op_rsp_data", 32'(rsp_data), 32'(ed));
    checkOutput("op_rsp_err", 32'(rsp_err), 32'(ee));
    waitIdle();
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [7:0] all_exp [7];
  int         all_ops [7];
  int         rr_exp  [5];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    op_p      = '0;
    a_p       = '0;
    b_p       = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    #2;
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);

    // Single XOR from requester 1
    @(posedge clk);
    #1;
    doOp(1, 3'd4, 8'hF0, 8'h3C, 8'hCC, 1'b0);

    // Every op code, including an illegal one
    all_ops = '{0, 1, 2, 3, 4, 5, 7};
    all_exp = '{8'h05, 8'hAF, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h00};
    for (int i = 0; i < 7; i++)
      doOp(i % N, 3'(all_ops[i]), 8'hA5, 8'h0F, all_exp[i], (all_ops[i] == 7));

    // Backpressure: the response must hold while requester 0 waits
    rsp_ready = 1'b0;
    applyStimulus(2, 3'd1, 8'h30, 8'h0C);
    op_p[0] = 3'd0;
    a_p[0]  = 8'hFF;
    b_p[0]  = 8'h81;
    req_valid[0] = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_rsp_id", 32'(rsp_id), 32'd2);
      checkOutput("bp_rsp_data", 32'(rsp_data), 32'h3C);
      checkOutput("bp_busy", 32'(busy), 32'd1);
      checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    req_valid[0] = 1'b0;
    applyStimulus(0, 3'd0, 8'hFF, 8'h81);
    waitIdle();

    // Contention with all four requesters valid continuously
    doReset();
    grant_log.delete();
    for (int i = 0; i < N; i++) begin
      op_p[i] = 3'd4;
      a_p[i]  = 8'(8'h11 * (i + 1));
      b_p[i]  = 8'h0F;
    end
    req_valid = '1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (grant_log.size() >= 5) break;
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    waitIdle();
`ifdef LOGIC_ARB_RR_EN
    rr_exp = '{0, 1, 2, 3, 0};
`else
    rr_exp = '{0, 0, 0, 0, 0};
`endif
    checkOutput("contention_count", 32'(grant_log.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++)
      if (i < grant_log.size())
        checkOutput("contention_grant", 32'(grant_log[i]), 32'(rr_exp[i]));

    // Reset while the op is in EXEC: the in-flight op is discarded
    applyStimulus(3, 3'd0, 8'hFF, 8'hFF);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    doOp(1, 3'd2, 8'hFF, 8'h0F, 8'hF0, 1'b0);

    // Requester 2 withdraws while the unit is busy
    grant_log.delete();
    applyStimulus(0, 3'd5, 8'h12, 8'h34);
    op_p[2] = 3'd1;
    a_p[2]  = 8'h77;
    b_p[2]  = 8'h88;
    req_valid[2] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    waitIdle();
    repeat (4) @(posedge clk);
    #1;
    checkOutput("withdraw_grants", 32'(grant_log.size()), 32'd1);
    checkOutput("withdraw_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
